// File: rtl/spi_pkg.sv
// Shared SPI definitions: controller state encoding and default geometry.
// Any SPI block, including a slave model, can import this package.
package spi_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLead,
    StXfer,
    StTrail
  } spi_state_e;

  localparam int unsigned DefaultWidth  = 8;
  localparam int unsigned DefaultClkDiv = 2;

endpackage

// File: rtl/spi_master_if.sv
// Host-side handshake plus serial pins of the SPI master.
// The master modport is the controller's view; the slave modport is the opposite side.
interface spi_master_if import spi_pkg::*; #(
  parameter int unsigned WIDTH = DefaultWidth
) ();

  logic             start;
  logic [WIDTH-1:0] masterDataIN;
  logic             cpha;
  logic [WIDTH-1:0] masterDataOUT;
  logic             busy;
  logic             done;
  logic             sclk;
  logic             cs;
  logic             mosi;
  logic             miso;

  modport master (
    input  start, masterDataIN, cpha, miso,
    output masterDataOUT, busy, done, sclk, cs, mosi
  );

  modport slave (
    output start, masterDataIN, cpha, miso,
    input  masterDataOUT, busy, done, sclk, cs, mosi
  );

endinterface

// File: rtl/spi_clkgen.sv
// Half-period tick generator and sclk toggle flop for the SPI master.
// The counter free-runs only while enabled, so the first tick lands CLK_DIV cycles after enable.
module spi_clkgen import spi_pkg::*; #(
  parameter int unsigned CLK_DIV = DefaultClkDiv
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic toggle,
  output logic tick,
  output logic sclk
);

  logic [7:0] cnt_q;
  logic       sclk_q;

  assign tick = en && (cnt_q == 8'(CLK_DIV - 1));
  assign sclk = sclk_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else if (!en) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
      if (toggle) sclk_q <= ~sclk_q;
    end else begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

endmodule

// File: rtl/spi_master.sv
// SPI master, CPOL=0, selectable CPHA per transfer, MSB first.
// One FSM owns cs/mosi/shift registers; spi_clkgen paces the sclk half-periods.
module spi_master import spi_pkg::*; #(
  parameter int unsigned CLK_DIV = DefaultClkDiv,
  parameter int unsigned WIDTH   = DefaultWidth
) (
  input  logic         clk,
  input  logic         reset,
  spi_master_if.master bus
);

  localparam int unsigned     CntW     = $clog2(2 * WIDTH);
  localparam logic [CntW-1:0] LastEdge = CntW'(2 * WIDTH - 1);

  spi_state_e       state_q;
  logic             cs_q, mosi_q, busy_q, done_q, cpha_q;
  logic [WIDTH-1:0] tx_q, rx_q, dout_q;
  logic [CntW-1:0]  edge_cnt_q;
  logic             tick, sclk, clk_en, clk_toggle;

  // LEAD is a one-cycle cs setup slot; pacing starts in XFER so edges fall at T0+1+k*CLK_DIV.
  assign clk_en     = (state_q == StXfer) || (state_q == StTrail);
  assign clk_toggle = (state_q == StXfer);

  spi_clkgen #(
    .CLK_DIV(CLK_DIV)
  ) u_clkgen (
    .clk   (clk),
    .reset (reset),
    .en    (clk_en),
    .toggle(clk_toggle),
    .tick  (tick),
    .sclk  (sclk)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      cs_q       <= 1'b1;
      mosi_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cpha_q     <= 1'b0;
      tx_q       <= '0;
      rx_q       <= '0;
      dout_q     <= '0;
      edge_cnt_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          busy_q <= 1'b0;
          // done_q marks the pulse cycle, during which a new start is not taken.
          if (bus.start && !done_q) begin
            state_q    <= StLead;
            cs_q       <= 1'b0;
            busy_q     <= 1'b1;
            cpha_q     <= bus.cpha;
            rx_q       <= '0;
            edge_cnt_q <= '0;
            if (bus.cpha) begin
              tx_q   <= bus.masterDataIN;
              mosi_q <= 1'b0;
            end else begin
              tx_q   <= bus.masterDataIN << 1;
              mosi_q <= bus.masterDataIN[WIDTH-1];
            end
          end
        end
        StLead: state_q <= StXfer;
        StXfer: begin
          if (tick) begin
            if (!sclk) begin
              if (cpha_q) begin
                mosi_q <= tx_q[WIDTH-1];
                tx_q   <= tx_q << 1;
              end else begin
                rx_q <= {rx_q[WIDTH-2:0], bus.miso};
              end
            end else if (cpha_q) begin
              rx_q <= {rx_q[WIDTH-2:0], bus.miso};
            end else if (edge_cnt_q != LastEdge) begin
              mosi_q <= tx_q[WIDTH-1];
              tx_q   <= tx_q << 1;
            end
            if (edge_cnt_q == LastEdge) state_q <= StTrail;
            else                        edge_cnt_q <= edge_cnt_q + 1'b1;
          end
        end
        StTrail: begin
          if (tick) begin
            state_q <= StIdle;
            cs_q    <= 1'b1;
            mosi_q  <= 1'b0;
            done_q  <= 1'b1;
            dout_q  <= rx_q;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.cs            = cs_q;
  assign bus.mosi          = mosi_q;
  assign bus.sclk          = sclk;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.masterDataOUT = dout_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed + randomized bench for spi_master: a bus-level slave model on a CLK_DIV=2 instance,
// and a mosi->miso loopback on a CLK_DIV=1 instance for back-to-back transfers.
module tb_spi_master;

  localparam int unsigned W  = 8;
  localparam int unsigned D0 = 2;
  localparam int unsigned D1 = 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int unsigned passed = 0;
  int unsigned total  = 0;

  spi_master_if #(.WIDTH(W)) bus0 ();
  spi_master_if #(.WIDTH(W)) bus1 ();

  spi_master #(.CLK_DIV(D0), .WIDTH(W)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  spi_master #(.CLK_DIV(D1), .WIDTH(W)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  // Slave model: shifts s_tx out on miso, collects mosi into s_rx, per SPI mode 0/1 rules.
  logic [W-1:0] s_tx, s_sh, s_rx;
  logic         s_ph, s_miso;
  assign bus0.miso = s_miso;
  assign bus1.miso = bus1.mosi;

  always @(negedge bus0.cs) begin
    s_sh   = s_tx;
    s_rx   = '0;
    s_miso = s_ph ? 1'b0 : s_sh[W-1];
  end
  always @(posedge bus0.sclk) if (bus0.cs === 1'b0) begin
    if (s_ph) begin
      s_miso = s_sh[W-1];
      s_sh   = s_sh << 1;
    end else begin
      s_rx = {s_rx[W-2:0], bus0.mosi};
    end
  end
  always @(negedge bus0.sclk) if (bus0.cs === 1'b0) begin
    if (s_ph) begin
      s_rx = {s_rx[W-2:0], bus0.mosi};
    end else begin
      s_sh   = s_sh << 1;
      s_miso = s_sh[W-1];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // One transfer on dut0; pulse=1 re-asserts start mid-transfer, abort_rise>0 resets after that rise.
  task automatic xfer0(input logic [W-1:0] din, input logic ph, input logic [W-1:0] sdata,
                       input bit pulse, input int abort_rise);
    int   rises, edges, done_n;
    bit   timing_ok, hold_ok, no_done;
    logic prev;
    @(negedge clk);
    s_tx = sdata;
    s_ph = ph;
    bus0.masterDataIN = din;
    bus0.cpha         = ph;
    bus0.start        = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus0.start = 1'b0;
    chk("cs_low_after_start", bus0.cs, 0);
    chk("busy_after_start", bus0.busy, 1);
    if (!ph) chk("mosi_first_bit_cpha0", bus0.mosi, din[W-1]);
    rises = 0; edges = 0; done_n = -1; timing_ok = 1; hold_ok = 1; prev = 1'b0;
    for (int n = 1; n <= 200 && done_n < 0; n++) begin
      @(posedge clk);
      @(negedge clk);
      bus0.masterDataIN = W'($urandom);
      bus0.cpha         = 1'($urandom);
      bus0.start        = pulse && (n == 10);
      if (bus0.sclk !== prev) begin
        edges++;
        if (n != 1 + edges * D0) timing_ok = 0;
        if (bus0.sclk === 1'b1) rises++;
        prev = bus0.sclk;
      end
      if (bus0.done === 1'b1) done_n = n;
      if (bus0.busy !== 1'b1 || (bus0.cs !== 1'b0 && done_n < 0)) hold_ok = 0;
      if (abort_rise > 0 && rises == abort_rise) begin
        reset = 1'b1;
        #1;
        chk("abort_cs", bus0.cs, 1);
        chk("abort_sclk", bus0.sclk, 0);
        chk("abort_busy", bus0.busy, 0);
        chk("abort_mosi", bus0.mosi, 0);
        chk("abort_rx_cleared", bus0.masterDataOUT, 0);
        no_done = 1;
        repeat (3) begin
          @(negedge clk);
          if (bus0.done !== 1'b0) no_done = 0;
        end
        reset = 1'b0;
        repeat (3) begin
          @(negedge clk);
          if (bus0.done !== 1'b0 || bus0.cs !== 1'b1) no_done = 0;
        end
        chk("abort_no_done", no_done, 1);
        return;
      end
    end
    chk("latency", done_n, (2 * W + 1) * D0 + 1);
    chk("sclk_edges", edges, 2 * W);
    chk("sclk_rises", rises, W);
    chk("edge_timing", timing_ok, 1);
    chk("busy_cs_held", hold_ok, 1);
    chk("master_rx", bus0.masterDataOUT, sdata);
    chk("slave_rx", s_rx, din);
    @(negedge clk);
    chk("done_one_cycle", bus0.done, 0);
    chk("busy_drop", bus0.busy, 0);
    chk("cs_idle", bus0.cs, 1);
    chk("mosi_idle", bus0.mosi, 0);
    chk("rx_hold", bus0.masterDataOUT, sdata);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] cur;
    int           tf, gap, ndone;

    reset = 1'b1;
    s_tx = '0; s_ph = 1'b0; s_miso = 1'b0;
    bus0.start = 1'b0; bus0.masterDataIN = '0; bus0.cpha = 1'b0;
    bus1.start = 1'b0; bus1.masterDataIN = '0; bus1.cpha = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cs", bus0.cs, 1);
    chk("rst_sclk", bus0.sclk, 0);
    chk("rst_mosi", bus0.mosi, 0);
    chk("rst_busy", bus0.busy, 0);
    chk("rst_done", bus0.done, 0);
    chk("rst_dout", bus0.masterDataOUT, 0);
    chk("rst_cs_d1", bus1.cs, 1);
    reset = 1'b0;
    @(negedge clk);

    xfer0(8'hAD, 1'b0, 8'h5A, 1'b0, 0);
    xfer0(8'h69, 1'b1, 8'hC3, 1'b0, 0);
    xfer0(W'($urandom), 1'b0, W'($urandom), 1'b1, 0);
    xfer0(W'($urandom), 1'b1, W'($urandom), 1'b1, 0);
    for (int i = 0; i < 4; i++) xfer0(W'($urandom), 1'($urandom), W'($urandom), 1'b0, 0);

    // Back-to-back on the CLK_DIV=1 instance with start held high; loopback returns the sent word.
    cur = W'($urandom);
    @(negedge clk);
    bus1.masterDataIN = cur;
    bus1.cpha         = 1'($urandom);
    bus1.start        = 1'b1;
    tf = -1; gap = 0; ndone = 0;
    for (int c = 0; c < 200 && ndone < 3; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus1.cs === 1'b0 && tf < 0) begin
        tf = c;
        if (ndone > 0) chk("b2b_cs_gap", gap, 2);
      end
      if (bus1.cs === 1'b1 && tf < 0) gap++;
      if (bus1.done === 1'b1) begin
        chk("b2b_latency", c - tf, (2 * W + 1) * D1 + 1);
        chk("b2b_rx", bus1.masterDataOUT, cur);
        ndone++;
        tf  = -1;
        gap = 1;
        cur = W'($urandom);
        bus1.masterDataIN = cur;
        bus1.cpha         = 1'($urandom);
      end
    end
    chk("b2b_count", ndone, 3);
    bus1.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("b2b_idle_busy", bus1.busy, 0);
    chk("b2b_idle_cs", bus1.cs, 1);

    xfer0(W'($urandom), 1'b0, W'($urandom), 1'b0, 3);
    xfer0(8'hFF, 1'b0, W'($urandom), 1'b0, 0);
    xfer0(8'hFF, 1'b1, W'($urandom), 1'b0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
